// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus: three requester ports, physical VRAM port and the underrun flag.
// The arbiter connects through the slave modport; the requesters and VRAM use master.
interface vram_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          in_active;
    logic          bgw_req;
    logic [AW-1:0] bgw_addr;
    logic          bgw_gnt;
    logic          bgw_rvalid;
    logic [DW-1:0] bgw_rdata;
    logic          spr_req;
    logic [AW-1:0] spr_addr;
    logic          spr_gnt;
    logic          spr_rvalid;
    logic [DW-1:0] spr_rdata;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_q;
    logic          bgw_underrun;

    modport slave (
        input  in_active,
        input  bgw_req, bgw_addr, spr_req, spr_addr,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_q,
        output bgw_gnt, bgw_rvalid, bgw_rdata,
        output spr_gnt, spr_rvalid, spr_rdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_addr, mem_we, mem_wdata,
        output bgw_underrun
    );

    modport master (
        output in_active,
        output bgw_req, bgw_addr, spr_req, spr_addr,
        output host_req, host_we, host_addr, host_wdata,
        output mem_q,
        input  bgw_gnt, bgw_rvalid, bgw_rdata,
        input  spr_gnt, spr_rvalid, spr_rdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_addr, mem_we, mem_wdata,
        input  bgw_underrun
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter for BGW/SPR display fetches and host access, with a
// bounded host wait, fixed 2-cycle read return and a BGW underrun flag.
module vram_arbiter #(
    parameter int AW         = 12,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 16,
    parameter int CW         = 5
) (
    input logic          vga_clk,
    input logic          rst,
    vram_arbiter_if.slave bus
);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_BGW  = 2'd1;
    localparam logic [1:0] OWN_SPR  = 2'd2;
    localparam logic [1:0] OWN_HOST = 2'd3;

    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] wait_cnt;
    logic          force_host;
    logic          bgw_g, spr_g, host_g;
    logic [AW-1:0] gnt_addr;
    logic [1:0]    own_nxt, own_p0, own_p1;
    logic [DW-1:0] bgw_hold, spr_hold, host_hold;
    logic          underrun_r;
    logic [AW-1:0] mem_addr_r;
    logic          mem_we_r;
    logic [DW-1:0] mem_wdata_r;

    assign force_host = (wait_cnt >= STARVE_LIM);

    // Grants are held low during reset so nothing is accepted while state is cleared.
    always_comb begin
        bgw_g  = 1'b0;
        spr_g  = 1'b0;
        host_g = 1'b0;
        if (!rst) begin
            if (force_host || !bus.in_active) begin
                if (bus.host_req)     host_g = 1'b1;
                else if (bus.bgw_req) bgw_g  = 1'b1;
                else if (bus.spr_req) spr_g  = 1'b1;
            end else begin
                if (bus.bgw_req)       bgw_g  = 1'b1;
                else if (bus.spr_req)  spr_g  = 1'b1;
                else if (bus.host_req) host_g = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_addr = bus.bgw_addr;
        own_nxt  = OWN_NONE;
        if (host_g) begin
            gnt_addr = bus.host_addr;
            own_nxt  = bus.host_we ? OWN_NONE : OWN_HOST;
        end else if (bgw_g) begin
            gnt_addr = bus.bgw_addr;
            own_nxt  = OWN_BGW;
        end else if (spr_g) begin
            gnt_addr = bus.spr_addr;
            own_nxt  = OWN_SPR;
        end
    end

    // p0: address on mem_addr; p1: mem_q valid, returned to the tagged owner.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            mem_addr_r  <= '0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= '0;
            own_p0      <= OWN_NONE;
            own_p1      <= OWN_NONE;
            underrun_r  <= 1'b0;
            bgw_hold    <= '0;
            spr_hold    <= '0;
            host_hold   <= '0;
        end else begin
            if (!bus.host_req || host_g)
                wait_cnt <= '0;
            else if (wait_cnt != {CW{1'b1}})
                wait_cnt <= wait_cnt + 1'b1;

            mem_we_r <= host_g && bus.host_we;
            if (bgw_g || spr_g || host_g)
                mem_addr_r <= gnt_addr;
            if (host_g && bus.host_we)
                mem_wdata_r <= bus.host_wdata;

            own_p0     <= own_nxt;
            own_p1     <= own_p0;
            underrun_r <= bus.bgw_req && !bgw_g && bus.in_active;

            if (own_p1 == OWN_BGW)  bgw_hold  <= bus.mem_q;
            if (own_p1 == OWN_SPR)  spr_hold  <= bus.mem_q;
            if (own_p1 == OWN_HOST) host_hold <= bus.mem_q;
        end
    end

    assign bus.bgw_gnt      = bgw_g;
    assign bus.spr_gnt      = spr_g;
    assign bus.host_gnt     = host_g;
    assign bus.bgw_rvalid   = (own_p1 == OWN_BGW);
    assign bus.spr_rvalid   = (own_p1 == OWN_SPR);
    assign bus.host_rvalid  = (own_p1 == OWN_HOST);
    // Read data is live from VRAM on the valid cycle and holds its last value otherwise.
    assign bus.bgw_rdata    = (own_p1 == OWN_BGW)  ? bus.mem_q : bgw_hold;
    assign bus.spr_rdata    = (own_p1 == OWN_SPR)  ? bus.mem_q : spr_hold;
    assign bus.host_rdata   = (own_p1 == OWN_HOST) ? bus.mem_q : host_hold;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_we       = mem_we_r;
    assign bus.mem_wdata    = mem_wdata_r;
    assign bus.bgw_underrun = underrun_r;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic checked
// against a priority-list / return-queue reference model.
module tb_vram_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SM = 16;

    logic vga_clk = 1'b0;
    logic rst     = 1'b1;
    always #5 vga_clk = ~vga_clk;

    vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    vram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM), .CW(5)) dut (
        .vga_clk (vga_clk),
        .rst     (rst),
        .bus     (bus)
    );

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return (32'h9E3779B9 * {20'd0, a}) + 32'h01234567;
    endfunction

    // VRAM: synchronous read, one cycle after the address is presented.
    logic [31:0] ram     [0:4095];
    logic        wr_flag [0:4095] = '{default: 1'b0};
    always @(posedge vga_clk) begin
        if (bus.mem_we) begin
            ram[bus.mem_addr]     <= bus.mem_wdata;
            wr_flag[bus.mem_addr] <= 1'b1;
        end
        bus.mem_q <= wr_flag[bus.mem_addr] ? ram[bus.mem_addr] : init_val(bus.mem_addr);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        int          due;
        int          own;
        logic [31:0] data;
    } rd_t;
    rd_t         pend[$];
    logic [31:0] shadow [0:4095];
    logic [31:0] last_rd [3];
    int          cyc, wait_m;
    logic [11:0] e_addr;
    logic        e_we, e_unr;
    logic [31:0] e_wdata;

    task automatic model_reset();
        pend.delete();
        wait_m  = 0;
        e_addr  = '0;
        e_we    = 1'b0;
        e_wdata = '0;
        e_unr   = 1'b0;
        for (int i = 0; i < 3; i++) last_rd[i] = '0;
    endtask

    task automatic drive_idle();
        bus.bgw_req  = 1'b0; bus.bgw_addr  = '0;
        bus.spr_req  = 1'b0; bus.spr_addr  = '0;
        bus.host_req = 1'b0; bus.host_we   = 1'b0;
        bus.host_addr = '0;  bus.host_wdata = '0;
    endtask

    task automatic chk_reset_outputs();
        check("rst_bgw_gnt", bus.bgw_gnt, 0);
        check("rst_spr_gnt", bus.spr_gnt, 0);
        check("rst_host_gnt", bus.host_gnt, 0);
        check("rst_bgw_rvalid", bus.bgw_rvalid, 0);
        check("rst_spr_rvalid", bus.spr_rvalid, 0);
        check("rst_host_rvalid", bus.host_rvalid, 0);
        check("rst_bgw_rdata", bus.bgw_rdata, 0);
        check("rst_spr_rdata", bus.spr_rdata, 0);
        check("rst_host_rdata", bus.host_rdata, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_underrun", bus.bgw_underrun, 0);
    endtask

    // One clock cycle: check registered outputs, apply inputs, check grants, advance model.
    task automatic step(input logic act, input logic br, input logic [11:0] ba,
                        input logic sr, input logic [11:0] sa,
                        input logic hr, input logic hw, input logic [11:0] ha,
                        input logic [31:0] hd, output logic [2:0] g);
        logic [2:0]  expv;
        logic [2:0]  reqv;
        logic [11:0] addrs [3];
        int          order [3];
        int          win;
        @(negedge vga_clk);
        check("mem_we", bus.mem_we, e_we);
        check("mem_addr", bus.mem_addr, e_addr);
        check("mem_wdata", bus.mem_wdata, e_wdata);
        check("bgw_underrun", bus.bgw_underrun, e_unr);
        expv = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            expv[pend[0].own]    = 1'b1;
            last_rd[pend[0].own] = pend[0].data;
            void'(pend.pop_front());
        end
        check("bgw_rvalid", bus.bgw_rvalid, expv[0]);
        check("spr_rvalid", bus.spr_rvalid, expv[1]);
        check("host_rvalid", bus.host_rvalid, expv[2]);
        check("bgw_rdata", bus.bgw_rdata, last_rd[0]);
        check("spr_rdata", bus.spr_rdata, last_rd[1]);
        check("host_rdata", bus.host_rdata, last_rd[2]);

        bus.in_active = act;
        bus.bgw_req = br;  bus.bgw_addr = ba;
        bus.spr_req = sr;  bus.spr_addr = sa;
        bus.host_req = hr; bus.host_we = hw; bus.host_addr = ha; bus.host_wdata = hd;
        #1;
        reqv  = {hr, sr, br};
        addrs = '{ba, sa, ha};
        if (!act || wait_m >= SM) order = '{2, 0, 1};
        else                      order = '{0, 1, 2};
        win = -1;
        for (int i = 0; i < 3; i++)
            if (win < 0 && reqv[order[i]]) win = order[i];
        g = '0;
        if (win >= 0) g[win] = 1'b1;
        check("bgw_gnt", bus.bgw_gnt, g[0]);
        check("spr_gnt", bus.spr_gnt, g[1]);
        check("host_gnt", bus.host_gnt, g[2]);

        e_we = (win == 2) && hw;
        if (win >= 0) e_addr = addrs[win];
        if (e_we) e_wdata = hd;
        if (win >= 0 && !e_we) pend.push_back('{due: cyc + 2, own: win, data: shadow[addrs[win]]});
        if (e_we) shadow[ha] = hd;
        e_unr = br && !g[0] && act;
        if (!hr || g[2]) wait_m = 0;
        else if (wait_m < 31) wait_m++;
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        logic [2:0] g;
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    endtask

    initial begin
        logic [2:0]  g;
        int          got_at;
        logic        act, br, sr, hr, hw, bp, sp, hp;
        logic [11:0] ba, sa, ha;
        logic [31:0] hd;

        for (int i = 0; i < 4096; i++) shadow[i] = init_val(12'(i));
        model_reset();
        cyc = 0;

        // Reset with requests asserted: everything must read zero.
        bus.in_active = 1'b1;
        drive_idle();
        bus.bgw_req = 1'b1; bus.host_req = 1'b1; bus.spr_req = 1'b1;
        #1;
        chk_reset_outputs();
        drive_idle();
        @(negedge vga_clk);
        rst = 1'b0;

        // Active video, BGW and SPR held: BGW wins every cycle.
        for (int i = 0; i < 6; i++) step(1'b1, 1, 12'h010, 1, 12'h020, 0, 0, 0, 0, g);
        idle_steps(3);

        // Blanking: host read beats BGW, BGW follows next cycle.
        step(1'b0, 1, 12'h010, 0, 0, 1, 0, 12'h005, 0, g);
        step(1'b0, 1, 12'h010, 0, 0, 0, 0, 0, 0, g);
        idle_steps(3);

        // Host starvation under continuous BGW traffic in active video.
        got_at = -1;
        for (int i = 0; i < 24 && got_at < 0; i++) begin
            step(1'b1, 1, 12'h011, 0, 0, 1, 0, 12'h0AB, 0, g);
            if (g[2]) got_at = i;
        end
        check("starve_grant_cycle", got_at, SM);
        step(1'b1, 1, 12'h011, 0, 0, 0, 0, 0, 0, g);
        idle_steps(3);

        // Host write then read-after-write to the same address.
        step(1'b0, 0, 0, 0, 0, 1, 1, 12'h3FF, 32'hDEADBEEF, g);
        step(1'b0, 0, 0, 0, 0, 1, 0, 12'h3FF, 0, g);
        idle_steps(3);

        // Interleaved BGW, SPR, host read on consecutive cycles.
        step(1'b1, 1, 12'h030, 0, 0, 0, 0, 0, 0, g);
        step(1'b1, 0, 0, 1, 12'h040, 0, 0, 0, 0, g);
        step(1'b1, 0, 0, 0, 0, 1, 0, 12'h050, 0, g);
        idle_steps(4);

        // Reset one cycle after a BGW grant discards the in-flight read.
        step(1'b1, 1, 12'h060, 0, 0, 0, 0, 0, 0, g);
        @(posedge vga_clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        drive_idle();
        repeat (2) @(posedge vga_clk);
        model_reset();
        @(negedge vga_clk);
        rst = 1'b0;
        idle_steps(4);

        // Randomized traffic honouring the requester protocol.
        act = 1'b1; bp = 0; sp = 0; hp = 0;
        br = 0; sr = 0; hr = 0; hw = 0; ba = 0; sa = 0; ha = 0; hd = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 40) == 0) act = ~act;
            if (!bp) begin br = ($urandom_range(0, 7) != 0); ba = 12'($urandom_range(0, 63)); end
            if (!sp) begin sr = $urandom_range(0, 1) == 1;  sa = 12'($urandom_range(0, 63)); end
            if (!hp) begin
                hr = ($urandom_range(0, 2) == 0);
                hw = $urandom_range(0, 1) == 1;
                ha = 12'($urandom_range(0, 63));
                hd = $urandom;
            end
            step(act, br, ba, sr, sa, hr, hw, ha, hd, g);
            bp = br && !g[0];
            sp = sr && !g[1];
            hp = hr && !g[2];
        end
        idle_steps(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 32-bit VRAM between three requesters: the background/window renderer fetch port (BGW), the sprite renderer fetch port (SPR) and the host/CPU access port (HOST).
- Sits between the two renderers' vram32 address/data ports and the physical VRAM.
- Gives display fetches priority during active video and host accesses priority during blanking.
- Bounds host starvation with a wait counter and flags any display fetch the arbiter had to deny.

Parameters:
AW, 12, VRAM word-address width
DW, 32, VRAM data width
STARVE_MAX, 16, host wait cycles that force a host grant (range 1..2^CW-1)
CW, 5, width of the host wait counter

Ports:
vga_clk  in  1  pixel clock; all state on rising edge
rst  in  1  asynchronous active-high reset
in_active  in  1  1 = active video region (renderer de), 0 = blanking
bgw_req  in  1  BGW read request
bgw_addr  in  AW  BGW read address
bgw_gnt  out  1  BGW request accepted this cycle (combinational)
bgw_rvalid  out  1  bgw_rdata valid
bgw_rdata  out  DW  BGW read data
spr_req  in  1  SPR read request
spr_addr  in  AW  SPR read address
spr_gnt  out  1  SPR request accepted this cycle (combinational)
spr_rvalid  out  1  spr_rdata valid
spr_rdata  out  DW  SPR read data
host_req  in  1  host request; held until host_gnt
host_we  in  1  1 = write, 0 = read
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_gnt  out  1  host request accepted this cycle (combinational)
host_rvalid  out  1  host_rdata valid (reads only)
host_rdata  out  DW  host read data
mem_addr  out  AW  VRAM address (registered)
mem_we  out  1  VRAM write enable (registered)
mem_wdata  out  DW  VRAM write data (registered)
mem_q  in  DW  VRAM read data; valid 1 cycle after mem_addr presented
bgw_underrun  out  1  1-cycle pulse: bgw_req denied while in_active=1

Behaviour:
- At most one grant per cycle. Grants are combinational from the requests, the current in_active and the force flag.
- Priority when force=0 and in_active=1: BGW > SPR > HOST.
- Priority when force=0 and in_active=0: HOST > BGW > SPR.
- force = (wait_cnt >= STARVE_MAX). When force=1: HOST > BGW > SPR, regardless of in_active.
- wait_cnt (CW bits):
  - clears on reset, on host_gnt, and on any cycle with host_req=0;
  - otherwise increments by 1 each cycle host_req=1 and host_gnt=0;
  - saturates at 2^CW-1.
- On the clock edge after any grant: mem_addr <= granted address; mem_we <= (host granted & host_we); mem_wdata <= host_wdata when a host write is granted.
- Cycle with no grant: mem_we <= 0; mem_addr and mem_wdata hold their values.
- Read pipeline: a 2-stage owner tag (none/BGW/SPR/HOST) follows each granted read.
  - Grant at cycle N puts the address on mem_addr at N+1 and mem_q at N+2.
  - The owner's rvalid is asserted at N+2 with rdata = mem_q, registered through to that cycle.
  - Fixed latency is 2 cycles from grant to rvalid.
- Host writes produce no rvalid. Write data is in VRAM after the mem_we cycle.
- The rvalid outputs are mutually exclusive 1-cycle pulses. The rdata outputs hold their last value when rvalid=0.
- Back-to-back grants, including to different owners, are allowed every cycle. Returned data stays in grant order.
- Read-after-write to the same address by host: a read granted the cycle after the write returns the new data.
- bgw_underrun is registered: asserted the cycle after bgw_req=1, bgw_gnt=0 and in_active=1 occurred together.
- Reset, asserted asynchronously at any time:
  - all gnt/rvalid/mem_we/bgw_underrun = 0; mem_addr, mem_wdata and all rdata = 0;
  - wait_cnt = 0; tag pipe = none;
  - in-flight reads are discarded and produce no rvalid after reset releases.
- Requesters must not change address while their req=1 and gnt=0. Host must not drop host_req before host_gnt; if it does, the request is abandoned and wait_cnt clears.

Test Plan:
- Reset then in_active=1, bgw_req and spr_req held, BGW addr 0x010, SPR 0x020 -> bgw_gnt every cycle, spr_gnt never; bgw_rvalid 2 cycles after each grant with mem_q data.
- in_active=0, host read 0x005 plus BGW request in the same cycle -> host_gnt same cycle, bgw_gnt next cycle; host_rvalid at +2 with contents of 0x005, then bgw_rvalid one cycle later.
- in_active=1, bgw_req held continuously, host_req held (STARVE_MAX=16) -> host_gnt on the 17th cycle of waiting (wait_cnt=16); bgw_underrun pulses once the following cycle; wait_cnt returns to 0.
- Host write 0xDEADBEEF to 0x3FF, then host read 0x3FF on the next cycle -> mem_we high for exactly one cycle; host_rvalid returns 0xDEADBEEF; no rvalid for the write.
- Interleaved grants BGW, SPR, HOST-read on consecutive cycles -> bgw_rvalid, spr_rvalid, host_rvalid on consecutive cycles, each with its own address's data.
- Assert rst one cycle after a BGW grant, hold 2 cycles -> all outputs 0 immediately; no bgw_rvalid appears after release.
